// File: rtl/pwm_pkg.sv
// pwm_pkg: state encoding, count limits and count step helper shared by the PWM driver
package pwm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} pwm_state_e;
  localparam logic [7:0] PWM_COUNT_MAX = 8'd254;
  localparam int DEAD_W = 8;
  function automatic logic [7:0] count_next(input logic [7:0] c);
    return c == PWM_COUNT_MAX ? 8'd0 : c + 8'd1;
  endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: divides clock by PRESCALE into a one-clock tick strobe while run is high
// Ports: clock, reset_n (async, active-low), run (counter cleared while low), tick (strobe out)
module pwm_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] pcnt;
  assign tick = run && pcnt == W'(PRESCALE - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pcnt <= '0;
    else pcnt <= (!run || tick) ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/pwm_driver.sv
// pwm_driver: swerve-rotation motor PWM generator with period-boundary ratio/direction latching
// Ports: clock, reset_n (async, active-low), pwm_enable, pwm_update, pwm_ratio[7:0], pwm_direction (in);
//        pwm_done (1-clock apply pulse), pwm_signal, dir_out, ratio_applied[7:0] (out)
// Build option: define PWM_DEADTIME_EN to insert DEADTIME_PERIODS low periods on direction reversal
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 4
`ifdef PWM_DEADTIME_EN
  , parameter int DEADTIME_PERIODS = 2
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_signal,
  output logic       dir_out,
  output logic [7:0] ratio_applied
);
  pwm_state_e state, state_n;
  logic [7:0] count, count_d, ratio_d;
  logic dir_d, done_d, sig_d, first, tick, run, boundary, apply, reverse;
  // run drops the same edge enable falls, so counters and ratio clear without an extra clock
  assign run = pwm_enable && state != IDLE;
  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (run),
    .tick   (tick)
  );
  // first is high only in the opening RUN clock, which acts as a period boundary
  assign boundary = run && (first || (tick && count == PWM_COUNT_MAX));
`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0] dead_cnt, dead_d;
  assign reverse = boundary && pwm_update && state == RUN && pwm_direction != dir_out;
  // DEAD exit samples ratio/direction at that boundary regardless of pwm_update
  assign apply = boundary && ((pwm_update && state == RUN && !reverse) ||
                              (state == DEAD && dead_cnt == DEAD_W'(1)));
  assign dead_d = reverse ? DEAD_W'(DEADTIME_PERIODS) :
                  (state == DEAD && boundary) ? dead_cnt - 1'b1 : dead_cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) dead_cnt <= '0;
    else dead_cnt <= dead_d;
`else
  assign reverse = 1'b0;
  assign apply = boundary && pwm_update && state == RUN;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = !pwm_enable      ? IDLE :
              state == IDLE    ? RUN  :
              reverse          ? DEAD :
              apply            ? RUN  : state;
  always_comb begin
    count_d = !run ? 8'd0 : tick ? count_next(count) : count;
    ratio_d = !run ? 8'd0 : apply ? pwm_ratio : reverse ? 8'd0 : ratio_applied;
    dir_d   = apply ? pwm_direction : dir_out;
    done_d  = apply;
    sig_d   = pwm_enable && state == RUN && count < ratio_applied;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count         <= '0;
      ratio_applied <= '0;
      dir_out       <= 1'b0;
      pwm_done      <= 1'b0;
      pwm_signal    <= 1'b0;
      first         <= 1'b1;
    end else begin
      count         <= count_d;
      ratio_applied <= ratio_d;
      dir_out       <= dir_d;
      pwm_done      <= done_d;
      pwm_signal    <= sig_d;
      first         <= state == IDLE;
    end
endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver: period-arithmetic model plus directed scenarios for pwm_driver
module tb_pwm_driver;
  localparam int P = 4;
  localparam int PER = 255 * P;
  localparam int DP = 2;
`ifdef PWM_DEADTIME_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pwm_enable = 1'b0, pwm_update = 1'b0, pwm_direction = 1'b0;
  logic [7:0] pwm_ratio = 8'd0;
  logic pwm_done, pwm_signal, dir_out;
  logic [7:0] ratio_applied;
  int n_vec = 0, n_err = 0;
  pwm_driver #(.PRESCALE(P)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .pwm_done     (pwm_done),
    .pwm_signal   (pwm_signal),
    .dir_out      (dir_out),
    .ratio_applied(ratio_applied)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: mode 0 idle, 1 run, 2 dead; k = clocks since the run started, count = (k/P) mod 255
  int ms = 0, k = 0, mratio = 0, mdead = 0;
  bit mdir = 0, mdone = 0, msig = 0, bnd;
  always begin
    @(posedge clock);
    if (!reset_n) begin
      ms = 0; k = 0; mratio = 0; mdir = 0; mdone = 0; msig = 0; mdead = 0;
    end else if (!pwm_enable) begin
      ms = 0; mratio = 0; mdone = 0; msig = 0;
    end else if (ms == 0) begin
      ms = 1; k = 0; mdone = 0; msig = 0;
    end else begin
      bnd = (k == 0) || (k % PER == PER - 1);
      msig = (ms == 1) && ((k / P) % 255 < mratio);
      mdone = 0;
      if (bnd && ms == 1 && pwm_update) begin
        if (REV && pwm_direction != mdir) begin
          mratio = 0; mdead = DP; ms = 2;
        end else begin
          mratio = int'(pwm_ratio); mdir = pwm_direction; mdone = 1;
        end
      end else if (bnd && ms == 2) begin
        if (mdead == 1) begin
          mratio = int'(pwm_ratio); mdir = pwm_direction; mdone = 1; ms = 1;
        end else mdead--;
      end
      k++;
    end
    #1;
    chk("model_sig", int'(pwm_signal), int'(msig));
    chk("model_done", int'(pwm_done), int'(mdone));
    chk("model_dir", int'(dir_out), int'(mdir));
    chk("model_ratio", int'(ratio_applied), mratio);
  end
  task automatic wait_done(input int bound, output int edges);
    edges = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clock); #1;
      if (pwm_done) begin
        edges = i;
        break;
      end
    end
  endtask
  task automatic measure(input int n, output int highs, output int dones);
    highs = 0;
    dones = 0;
    repeat (n) begin
      @(posedge clock); #1;
      highs += int'(pwm_signal);
      dones += int'(pwm_done);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int e, h, d;
    repeat (3) @(negedge clock);
    chk("rst_sig", int'(pwm_signal), 0);
    chk("rst_done", int'(pwm_done), 0);
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_ratio", int'(ratio_applied), 0);
    reset_n = 1'b1;
    @(negedge clock);
    pwm_enable = 1'b1; pwm_update = 1'b1; pwm_ratio = 8'd64;
    wait_done(5, e);
    chk("t1_done_latency", e, 2);
    chk("t1_ratio", int'(ratio_applied), 64);
    wait_done(1100, e);
    chk("t1_first_period", e, 1019);
    measure(PER, h, d);
    chk("t1_high", h, 256);
    chk("t1_dones", d, 1);
    @(negedge clock); pwm_ratio = 8'd0;
    measure(PER, h, d);
    chk("t2_old64_high", h, 256);
    chk("t2_old64_dones", d, 1);
    @(negedge clock); pwm_ratio = 8'd255;
    measure(PER, h, d);
    chk("t2_zero_high", h, 0);
    chk("t2_zero_dones", d, 1);
    @(negedge clock); pwm_ratio = 8'd64;
    measure(PER, h, d);
    chk("t2_full_high", h, PER);
    chk("t2_full_dones", d, 1);
    measure(100, h, d);
    chk("t3_pre_high", h, 100);
    @(negedge clock); pwm_ratio = 8'd128;
    measure(PER - 100, h, d);
    chk("t3_post_high", h, 156);
    chk("t3_dones", d, 1);
    chk("t3_ratio", int'(ratio_applied), 128);
    measure(PER, h, d);
    chk("t3_new_high", h, 512);
    @(negedge clock); pwm_direction = 1'b1; pwm_ratio = 8'd100;
    measure(PER, h, d);
    chk("t4_rev_high", h, 512);
    if (REV) begin
      chk("t4_rev_dones", d, 0);
      chk("t4_dead_ratio", int'(ratio_applied), 0);
      chk("t4_dead_dir", int'(dir_out), 0);
      measure(PER, h, d);
      chk("t4_dead1_high", h, 0);
      chk("t4_dead1_dones", d, 0);
      measure(PER, h, d);
      chk("t4_dead2_high", h, 0);
    end
    chk("t4_apply_dones", d, 1);
    chk("t4_dir", int'(dir_out), 1);
    chk("t4_ratio", int'(ratio_applied), 100);
    measure(PER, h, d);
    chk("t4_new_high", h, 400);
    measure(50, h, d);
    chk("t5_pre_high", h, 50);
    @(negedge clock); pwm_enable = 1'b0;
    @(posedge clock); #1;
    chk("t5_sig_off", int'(pwm_signal), 0);
    chk("t5_ratio_off", int'(ratio_applied), 0);
    chk("t5_dir_held", int'(dir_out), 1);
    repeat (10) @(negedge clock);
    pwm_enable = 1'b1;
    wait_done(5, e);
    chk("t5_reenable_latency", e, 2);
    measure(PER - 1, h, d);
    chk("t5_restart_high", h, 399);
    chk("t5_restart_dones", d, 1);
    if (REV) begin
      @(negedge clock); pwm_direction = 1'b0;
      measure(PER, h, d);
      chk("t6_rev_high", h, 400);
      chk("t6_rev_dones", d, 0);
      measure(500, h, d);
      chk("t6_dead_high", h, 0);
    end else begin
      measure(200, h, d);
      chk("t6_mid_high", h, 200);
    end
    @(negedge clock); #3 reset_n = 1'b0;
    #1;
    chk("t6_async_sig", int'(pwm_signal), 0);
    chk("t6_async_done", int'(pwm_done), 0);
    chk("t6_async_dir", int'(dir_out), 0);
    chk("t6_async_ratio", int'(ratio_applied), 0);
    pwm_update = 1'b0; pwm_ratio = 8'd200;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    measure(2100, h, d);
    chk("t6_noupd_high", h, 0);
    chk("t6_noupd_dones", d, 0);
    chk("t6_noupd_ratio", int'(ratio_applied), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
